// File: rtl/uart_pkg.sv
// Shared types and constants for the UART with RTS/CTS flow control.
package uart_pkg;

  localparam int SYNC_STAGES = 2;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read and occupancy output.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         wr_en,
  input  logic [WIDTH-1:0]             wr_data,
  input  logic                         rd_en,
  output logic [WIDTH-1:0]             rd_data,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         full,
  output logic                         empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [LVL_W-1:0] level_reg;
  logic             do_wr;
  logic             do_rd;

  assign full  = (level_reg == LVL_W'(DEPTH));
  assign empty = (level_reg == '0);
  assign level = level_reg;

  // A write into a full FIFO is accepted only when a pop frees the slot in the same cycle.
  assign do_wr = wr_en && (!full || rd_en);
  assign do_rd = rd_en && !empty;

  // Head is forced to zero while empty so the output is clean during and after reset.
  assign rd_data = empty ? '0 : mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_rd) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({do_wr, do_rd})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
    end
  end

endmodule

// File: rtl/uart_flow_ctrl.sv
// UART transmitter/receiver with TX/RX FIFOs and optional RTS/CTS hardware handshake.
module uart_flow_ctrl
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = 434,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int FLOW_CTRL  = 1,
  parameter int RTS_MARGIN = 2
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [DATA_BITS-1:0]              tx_data,
  input  logic                              tx_valid,
  output logic                              tx_ready,
  output logic [DATA_BITS-1:0]              rx_data,
  output logic                              rx_valid,
  input  logic                              rx_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   tx_level,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   rx_level,
  output logic                              frame_err,
  output logic                              overrun,
  input  logic                              rxd,
  output logic                              txd,
  input  logic                              cts_n,
  output logic                              rts_n
);

  localparam int LVL_W = $clog2(FIFO_DEPTH+1);
  localparam int CNT_W = $clog2(CLK_DIV);
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV / 2 - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);

  logic [SYNC_STAGES-1:0] cts_sync_reg;
  logic [SYNC_STAGES-1:0] rxd_sync_reg;
  logic                   cts_s;
  logic                   rx_s;
  logic                   tx_en;

  logic                   ready_reg;
  logic                   rts_n_reg;
  logic                   frame_err_reg;
  logic                   overrun_reg;
  logic                   overrun_next;
  logic [LVL_W-1:0]       rx_free;

  logic                   tx_full;
  logic                   tx_empty;
  logic                   tx_pop;
  logic [DATA_BITS-1:0]   tx_head;
  logic                   rx_full;
  logic                   rx_empty;
  logic                   rx_pop;
  logic                   rx_push;

  tx_state_t              tx_state_reg, tx_state_next;
  logic [CNT_W-1:0]       tx_cnt_reg, tx_cnt_next;
  logic [BIT_W-1:0]       tx_bit_reg, tx_bit_next;
  logic [DATA_BITS-1:0]   tx_shift_reg, tx_shift_next;
  logic                   txd_reg, txd_next;

  rx_state_t              rx_state_reg, rx_state_next;
  logic [CNT_W-1:0]       rx_cnt_reg, rx_cnt_next;
  logic [BIT_W-1:0]       rx_bit_reg, rx_bit_next;
  logic [DATA_BITS-1:0]   rx_shift_reg, rx_shift_next;
  logic                   rx_armed_reg, rx_armed_next;
  logic                   frame_err_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cts_sync_reg <= '1;
      rxd_sync_reg <= '1;
    end else begin
      cts_sync_reg <= {cts_sync_reg[SYNC_STAGES-2:0], cts_n};
      rxd_sync_reg <= {rxd_sync_reg[SYNC_STAGES-2:0], rxd};
    end
  end

  assign cts_s = cts_sync_reg[SYNC_STAGES-1];
  assign rx_s  = rxd_sync_reg[SYNC_STAGES-1];
  assign tx_en = (FLOW_CTRL == 0) || !cts_s;

  sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (tx_valid && tx_ready),
    .wr_data (tx_data),
    .rd_en   (tx_pop),
    .rd_data (tx_head),
    .level   (tx_level),
    .full    (tx_full),
    .empty   (tx_empty)
  );

  sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (rx_push),
    .wr_data (rx_shift_reg),
    .rd_en   (rx_pop),
    .rd_data (rx_data),
    .level   (rx_level),
    .full    (rx_full),
    .empty   (rx_empty)
  );

  assign tx_ready     = ready_reg && !tx_full;
  assign rx_valid     = !rx_empty;
  assign rx_pop       = rx_valid && rx_ready;
  assign overrun_next = rx_push && rx_full && !rx_pop;
  assign rx_free      = LVL_W'(FIFO_DEPTH) - rx_level;

  assign txd       = txd_reg;
  assign rts_n     = rts_n_reg;
  assign frame_err = frame_err_reg;
  assign overrun   = overrun_reg;

  // ready_reg keeps tx_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ready_reg     <= 1'b0;
      rts_n_reg     <= 1'b1;
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      ready_reg     <= 1'b1;
      rts_n_reg     <= (FLOW_CTRL != 0) ? (rx_free <= LVL_W'(RTS_MARGIN)) : 1'b0;
      frame_err_reg <= frame_err_next;
      overrun_reg   <= overrun_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_state_reg <= TX_IDLE;
      tx_cnt_reg   <= '0;
      tx_bit_reg   <= '0;
      tx_shift_reg <= '0;
      txd_reg      <= 1'b1;
    end else begin
      tx_state_reg <= tx_state_next;
      tx_cnt_reg   <= tx_cnt_next;
      tx_bit_reg   <= tx_bit_next;
      tx_shift_reg <= tx_shift_next;
      txd_reg      <= txd_next;
    end
  end

  // txd is registered from the current state, so the line trails the state by one cycle.
  always_comb begin
    tx_state_next = tx_state_reg;
    tx_cnt_next   = tx_cnt_reg;
    tx_bit_next   = tx_bit_reg;
    tx_shift_next = tx_shift_reg;
    tx_pop        = 1'b0;
    txd_next      = 1'b1;
    case (tx_state_reg)
      TX_IDLE: begin
        if (!tx_empty && tx_en) begin
          tx_state_next = TX_START;
          tx_pop        = 1'b1;
          tx_shift_next = tx_head;
          tx_cnt_next   = BIT_LAST;
        end
      end
      TX_START: begin
        txd_next = 1'b0;
        if (tx_cnt_reg == '0) begin
          tx_state_next = TX_DATA;
          tx_cnt_next   = BIT_LAST;
          tx_bit_next   = '0;
        end else begin
          tx_cnt_next = tx_cnt_reg - 1'b1;
        end
      end
      TX_DATA: begin
        txd_next = tx_shift_reg[0];
        if (tx_cnt_reg == '0) begin
          tx_cnt_next   = BIT_LAST;
          tx_shift_next = tx_shift_reg >> 1;
          if (tx_bit_reg == DATA_LAST) begin
            tx_state_next = TX_STOP;
          end else begin
            tx_bit_next = tx_bit_reg + 1'b1;
          end
        end else begin
          tx_cnt_next = tx_cnt_reg - 1'b1;
        end
      end
      TX_STOP: begin
        if (tx_cnt_reg == '0) begin
          if (!tx_empty && tx_en) begin
            tx_state_next = TX_START;
            tx_pop        = 1'b1;
            tx_shift_next = tx_head;
            tx_cnt_next   = BIT_LAST;
          end else begin
            tx_state_next = TX_IDLE;
          end
        end else begin
          tx_cnt_next = tx_cnt_reg - 1'b1;
        end
      end
      default: tx_state_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_state_reg <= RX_IDLE;
      rx_cnt_reg   <= '0;
      rx_bit_reg   <= '0;
      rx_shift_reg <= '0;
      rx_armed_reg <= 1'b1;
    end else begin
      rx_state_reg <= rx_state_next;
      rx_cnt_reg   <= rx_cnt_next;
      rx_bit_reg   <= rx_bit_next;
      rx_shift_reg <= rx_shift_next;
      rx_armed_reg <= rx_armed_next;
    end
  end

  // After a framing error the receiver waits for a high line before looking for a new start.
  always_comb begin
    rx_state_next  = rx_state_reg;
    rx_cnt_next    = rx_cnt_reg;
    rx_bit_next    = rx_bit_reg;
    rx_shift_next  = rx_shift_reg;
    rx_armed_next  = rx_armed_reg;
    rx_push        = 1'b0;
    frame_err_next = 1'b0;
    case (rx_state_reg)
      RX_IDLE: begin
        if (!rx_armed_reg) begin
          rx_armed_next = rx_s;
        end else if (!rx_s) begin
          rx_state_next = RX_START;
          rx_cnt_next   = HALF_LAST;
        end
      end
      RX_START: begin
        if (rx_cnt_reg == '0) begin
          if (rx_s) begin
            rx_state_next = RX_IDLE;
          end else begin
            rx_state_next = RX_DATA;
            rx_cnt_next   = BIT_LAST;
            rx_bit_next   = '0;
          end
        end else begin
          rx_cnt_next = rx_cnt_reg - 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_reg == '0) begin
          rx_shift_next = {rx_s, rx_shift_reg[DATA_BITS-1:1]};
          rx_cnt_next   = BIT_LAST;
          if (rx_bit_reg == DATA_LAST) begin
            rx_state_next = RX_STOP;
          end else begin
            rx_bit_next = rx_bit_reg + 1'b1;
          end
        end else begin
          rx_cnt_next = rx_cnt_reg - 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_reg == '0) begin
          rx_state_next = RX_IDLE;
          if (rx_s) begin
            rx_push = 1'b1;
          end else begin
            frame_err_next = 1'b1;
            rx_armed_next  = 1'b0;
          end
        end else begin
          rx_cnt_next = rx_cnt_reg - 1'b1;
        end
      end
      default: rx_state_next = RX_IDLE;
    endcase
  end

endmodule
